// File: rtl/load_store_unit_if.sv
// Bus bundle between the MEM stage, the load/store unit and data memory.
// The load/store unit is the master: it consumes the CPU request and
// initiates the memory transaction. The slave view is the environment.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    // CPU side
    logic              cpu_valid;
    logic              cpu_memRead;
    logic              cpu_memWrite;
    logic [1:0]        cpu_size;
    logic              cpu_unsigned;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_writeData;
    logic              cpu_busy;
    logic              cpu_done;
    logic [31:0]       cpu_readData;
    logic              cpu_fault;
    logic [1:0]        cpu_faultCode;
    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_writeData;
    logic [3:0]        mem_byteEnable;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_readData;
    logic              mem_ready;

    modport master (
        input  cpu_valid, cpu_memRead, cpu_memWrite, cpu_size, cpu_unsigned,
               cpu_addr, cpu_writeData, mem_readData, mem_ready,
        output cpu_busy, cpu_done, cpu_readData, cpu_fault, cpu_faultCode,
               mem_addr, mem_writeData, mem_byteEnable, mem_read, mem_write
    );

    modport slave (
        output cpu_valid, cpu_memRead, cpu_memWrite, cpu_size, cpu_unsigned,
               cpu_addr, cpu_writeData, mem_readData, mem_ready,
        input  cpu_busy, cpu_done, cpu_readData, cpu_fault, cpu_faultCode,
               mem_addr, mem_writeData, mem_byteEnable, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from the MEM stage, checks
// legality and alignment, issues a word-addressed byte-enabled request to
// data memory, and returns extended load data. A watchdog turns a missing
// mem_ready into a timeout fault.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic               clock,
    input logic               reset,
    load_store_unit_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CODE_MISALIGNED = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT    = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL    = 2'b11;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic             op_read;
    logic [1:0]       op_size;
    logic             op_unsigned;
    logic [1:0]       op_lane;

    logic             accept;
    logic             complete;
    logic             expire;
    logic             fault;
    logic [1:0]       fault_code;
    logic             illegal;
    logic             misaligned;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // The selected lane is shifted down to bit 0 before extension.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic zero_ext);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   return zero_ext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   return zero_ext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    assign illegal    = (bus.cpu_memRead == bus.cpu_memWrite) || (bus.cpu_size == 2'b11);
    assign misaligned = ((bus.cpu_size == 2'b01) && bus.cpu_addr[0]) ||
                        ((bus.cpu_size == 2'b10) && (bus.cpu_addr[1:0] != 2'b00));

    assign bus.cpu_busy = (state == ACCESS);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: classify the IDLE request, watch for ready or expiry in ACCESS
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        fault      = 1'b0;
        fault_code = 2'b00;
        case (state)
            IDLE: begin
                if (bus.cpu_valid) begin
                    if (illegal) begin
                        fault      = 1'b1;
                        fault_code = CODE_ILLEGAL;
                    end else if (misaligned) begin
                        fault      = 1'b1;
                        fault_code = CODE_MISALIGNED;
                    end else begin
                        accept     = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready in the final watchdog cycle still completes normally.
                if (bus.mem_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (count == LAST) begin
                    expire     = 1'b1;
                    fault      = 1'b1;
                    fault_code = CODE_TIMEOUT;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered bus outputs, latched op fields, watchdog counter and CPU results
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.mem_addr       <= '0;
            bus.mem_writeData  <= '0;
            bus.mem_byteEnable <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.cpu_done       <= 1'b0;
            bus.cpu_fault      <= 1'b0;
            bus.cpu_faultCode  <= '0;
            bus.cpu_readData   <= '0;
            count              <= '0;
            op_read            <= 1'b0;
            op_size            <= '0;
            op_unsigned        <= 1'b0;
            op_lane            <= '0;
        end else begin
            bus.cpu_done  <= complete;
            bus.cpu_fault <= fault;
            if (fault) begin
                bus.cpu_faultCode <= fault_code;
            end
            if (accept) begin
                bus.mem_addr       <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                bus.mem_byteEnable <= lane_enable(bus.cpu_size, bus.cpu_addr[1:0]);
                bus.mem_writeData  <= replicate(bus.cpu_size, bus.cpu_writeData);
                bus.mem_read       <= bus.cpu_memRead;
                bus.mem_write      <= bus.cpu_memWrite;
                op_read            <= bus.cpu_memRead;
                op_size            <= bus.cpu_size;
                op_unsigned        <= bus.cpu_unsigned;
                op_lane            <= bus.cpu_addr[1:0];
                count              <= '0;
            end else if (complete || expire) begin
                bus.mem_addr       <= '0;
                bus.mem_byteEnable <= '0;
                bus.mem_writeData  <= '0;
                bus.mem_read       <= 1'b0;
                bus.mem_write      <= 1'b0;
                count              <= '0;
                if (complete && op_read) begin
                    bus.cpu_readData <= extract(bus.mem_readData, op_size, op_lane, op_unsigned);
                end
            end else if (state == ACCESS) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level memory model predicts every bus
// request and every CPU response; a responder plays data memory with a
// per-transaction latency; a monitor pops and compares expectations.
module tb_load_store_unit;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          held;
    } req_t;

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        logic [31:0] rdata;
        int          at;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   lat_q[$];

    logic [7:0]  ref_mem[0:63];
    logic [7:0]  bus_mem[0:63];
    logic [31:0] model_rdata;
    logic [1:0]  model_code;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts request and response, then drives the CPU strobe.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int lat);
        int          n;
        int          lane;
        int          k;
        int          budget;
        req_t        rq;
        rsp_t        rs;
        logic [31:0] v;
        @(negedge clock);
        budget = 0;
        while (bus.cpu_busy && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (bus.cpu_busy) check("busy_wait", 32'd1, 32'd0);
        k    = cyc + 1;
        n    = 1 << size;
        lane = int'(addr % 4);
        if (rd == wr || size == 2'd3) begin
            model_code  = 2'b11;
            rs.is_fault = 1'b1;
            rs.code     = model_code;
            rs.rdata    = model_rdata;
            rs.at       = k;
            rsp_q.push_back(rs);
        end else if (addr % n != 0) begin
            model_code  = 2'b01;
            rs.is_fault = 1'b1;
            rs.code     = model_code;
            rs.rdata    = model_rdata;
            rs.at       = k;
            rsp_q.push_back(rs);
        end else begin
            rq.rd   = rd;
            rq.wr   = wr;
            rq.addr = addr - addr % 4;
            rq.be   = 4'(((1 << n) - 1) << lane);
            for (int j = 0; j < 4; j++) rq.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
            rq.held = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
            req_q.push_back(rq);
            lat_q.push_back(lat);
            if (lat >= TIMEOUT) begin
                model_code  = 2'b10;
                rs.is_fault = 1'b1;
            end else begin
                rs.is_fault = 1'b0;
                if (rd) begin
                    v = 32'd0;
                    for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[addr + i]} << (8 * i));
                    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                    model_rdata = v;
                end else begin
                    for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
                end
            end
            rs.code  = model_code;
            rs.rdata = model_rdata;
            rs.at    = k + rq.held;
            rsp_q.push_back(rs);
        end
        bus.cpu_valid     = 1'b1;
        bus.cpu_memRead   = rd;
        bus.cpu_memWrite  = wr;
        bus.cpu_size      = size;
        bus.cpu_unsigned  = uns;
        bus.cpu_addr      = addr;
        bus.cpu_writeData = wd;
        @(posedge clock);
        #1 bus.cpu_valid = 1'b0;
    endtask

    // Data memory responder: ready after the planned latency, random ready while idle
    int rcnt;
    int rlat;
    always @(negedge clock) begin
        if (reset) begin
            rcnt          = 0;
            bus.mem_ready = 1'b0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (rcnt == 0) rlat = (lat_q.size() > 0) ? lat_q.pop_front() : NEVER;
            if (rcnt == rlat) begin
                bus.mem_ready = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    bus.mem_readData[8*j +: 8] = bus_mem[{bus.mem_addr[5:2], 2'(j)}];
                    if (bus.mem_write && bus.mem_byteEnable[j])
                        bus_mem[{bus.mem_addr[5:2], 2'(j)}] = bus.mem_writeData[8*j +: 8];
                end
            end else begin
                bus.mem_ready    = 1'b0;
                bus.mem_readData = $urandom;
            end
            rcnt++;
        end else begin
            rcnt             = 0;
            bus.mem_ready    = 1'($urandom_range(0, 1));
            bus.mem_readData = $urandom;
        end
    end

    // Monitor: compare bus requests and CPU responses against the queues
    req_t cur;
    bit   active;
    int   held_cnt;
    rsp_t got;
    always @(negedge clock) begin
        if (reset) begin
            active = 1'b0;
        end else begin
            if (bus.mem_read || bus.mem_write) begin
                if (!active) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_request", 32'd1, 32'd0);
                    end else begin
                        cur      = req_q.pop_front();
                        active   = 1'b1;
                        held_cnt = 0;
                    end
                end
                if (active) begin
                    check("req_read", 32'(bus.mem_read), 32'(cur.rd));
                    check("req_write", 32'(bus.mem_write), 32'(cur.wr));
                    check("req_addr", bus.mem_addr, cur.addr);
                    check("req_be", 32'(bus.mem_byteEnable), 32'(cur.be));
                    if (cur.wr) check("req_wdata", bus.mem_writeData, cur.wdata);
                    held_cnt++;
                end
            end else if (active) begin
                check("req_held", 32'(held_cnt), 32'(cur.held));
                active = 1'b0;
            end
            if (bus.cpu_done || bus.cpu_fault) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    got = rsp_q.pop_front();
                    check("rsp_fault", 32'(bus.cpu_fault), 32'(got.is_fault));
                    check("rsp_done", 32'(bus.cpu_done), 32'(!got.is_fault));
                    check("rsp_cycle", 32'(cyc), 32'(got.at));
                    check("rsp_rdata", bus.cpu_readData, got.rdata);
                    check("rsp_code", 32'(bus.cpu_faultCode), 32'(got.code));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.cpu_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.cpu_done), 32'd0);
        check({tag, "_fault"}, 32'(bus.cpu_fault), 32'd0);
        check({tag, "_code"}, 32'(bus.cpu_faultCode), 32'd0);
        check({tag, "_rdata"}, bus.cpu_readData, 32'd0);
        check({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_be"}, 32'(bus.mem_byteEnable), 32'd0);
    endtask

    // Global watchdog against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // Directed scenarios, reset mid-access, then randomized traffic
    int          r;
    int          l;
    int          budget;
    bit          rrd;
    bit          rwr;
    logic [1:0]  rsize;
    logic [31:0] raddr;
    int          rlat_pick;
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cpu_valid = 1'b0; bus.cpu_memRead = 1'b0; bus.cpu_memWrite = 1'b0;
        bus.cpu_size = 2'b00; bus.cpu_unsigned = 1'b0; bus.cpu_addr = '0;
        bus.cpu_writeData = '0; bus.mem_ready = 1'b0; bus.mem_readData = '0;
        model_rdata = '0;
        model_code  = '0;
        active      = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        issue(0, 1, 2'b10, 0, 32'd4, 32'h0000_0124, 1);
        issue(1, 0, 2'b10, 0, 32'd4, 32'd0, 0);
        issue(0, 1, 2'b10, 0, 32'd4, 32'h0000_80FF, 0);
        issue(1, 0, 2'b00, 0, 32'd5, 32'd0, 0);
        issue(1, 0, 2'b00, 1, 32'd5, 32'd0, 0);
        issue(0, 1, 2'b10, 0, 32'd4, 32'hF00D_0000, 0);
        issue(1, 0, 2'b01, 0, 32'd6, 32'd0, 0);
        issue(0, 1, 2'b01, 0, 32'd10, 32'h1234_ABCD, 2);
        issue(0, 1, 2'b00, 0, 32'd3, 32'h0000_005A, 0);
        issue(1, 0, 2'b10, 0, 32'd8, 32'd0, 0);
        issue(1, 0, 2'b10, 0, 32'd0, 32'd0, 0);
        issue(1, 0, 2'b10, 0, 32'd6, 32'd0, 0);
        issue(1, 1, 2'b10, 0, 32'd4, 32'd0, 0);
        issue(1, 0, 2'b11, 0, 32'd4, 32'd0, 0);
        issue(0, 0, 2'b00, 0, 32'd4, 32'd0, 0);
        issue(1, 0, 2'b10, 0, 32'd12, 32'd0, NEVER);
        issue(1, 0, 2'b10, 0, 32'd12, 32'd0, TIMEOUT - 1);
        issue(1, 0, 2'b01, 0, 32'd6, 32'd0, 0);

        // Reset in the middle of an access that would otherwise time out
        issue(1, 0, 2'b10, 0, 32'd8, 32'd0, NEVER);
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        req_q.delete();
        rsp_q.delete();
        lat_q.delete();
        model_rdata = '0;
        model_code  = '0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(1, 0, 2'b10, 0, 32'd4, 32'd0, 1);

        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rrd = 1'b1; rwr = 1'b1;
            end else if (r == 1) begin
                rrd = 1'b0; rwr = 1'b0;
            end else begin
                rrd = 1'($urandom_range(0, 1)); rwr = !rrd;
            end
            rsize = (r == 2) ? 2'b11 : 2'($urandom_range(0, 2));
            raddr = $urandom_range(0, 63);
            if (rsize != 2'b11 && $urandom_range(0, 3) != 0)
                raddr = raddr - raddr % (32'd1 << rsize);
            l = $urandom_range(0, 11);
            if (l < 6)       rlat_pick = l % 3;
            else if (l == 6) rlat_pick = TIMEOUT - 1;
            else if (l == 7) rlat_pick = NEVER;
            else             rlat_pick = l - 6;
            issue(rrd, rwr, rsize, 1'($urandom_range(0, 1)), raddr, $urandom, rlat_pick);
        end

        budget = 0;
        while ((rsp_q.size() != 0 || bus.cpu_busy) && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        repeat (2) @(negedge clock);
        check("drain_responses", 32'(rsp_q.size()), 32'd0);
        check("drain_requests", 32'(req_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
